score_bcd: RTL and testbench
============================

# score_bcd

Game score keeper that sits directly upstream of the four-digit seven-segment scan driver. It counts score events from the game core as a 4-digit packed BCD value and holds a best-score register. It runs a small IDLE/PLAY/OVER state machine and drives the 16-bit BCD word the display driver scans. Digit 0 (units) is in x[3:0] and digit 3 (thousands) is in x[15:12].

## Interface
- WRAP, default 0: 0 = saturate at 9999; 1 = wrap 9999 -> 0000.
- cclk  in  1  clock; all state updates on the rising edge.
- clr  in  1  reset, asynchronous, active-high.
- start  in  1  synchronous pulse; begin a new game.
- over  in  1  synchronous pulse; game ended (bird collided).
- inc  in  1  score level from game core; each rising edge = +1.
- show_best  in  1  0 = x shows current score; 1 = x shows best.
- x  out  16  packed BCD to the display driver; combinational mux of the score/best registers.
- score  out  16  current score, packed BCD.
- best  out  16  best score, packed BCD.
- playing  out  1  high while state = PLAY.
- new_best  out  1  set when the last game beat the best score.
- sat  out  1  score held at 9999 (only possible when WRAP=0).

## Operation
- States: IDLE (after reset), PLAY, OVER.
- IDLE --start--> PLAY.
- OVER --start--> PLAY.
- PLAY --over--> OVER.
- start while in PLAY restarts the game: stays in PLAY, score clears.
- over outside PLAY is ignored.
- On entering PLAY (every start): score=0000, new_best=0, sat=0. best is kept.
- Edge detect: inc_q <= inc each cycle. An event is inc=1 && inc_q=0. It counts only in PLAY with no start that cycle.
- BCD increment, ripple across digits:
  - Digit d holding 9 with carry-in becomes 0 and carries out.
  - Otherwise digit d adds the carry-in.
  - Digit 0 carry-in = 1.
  - Every digit nibble stays in 0-9 at all times.
- At 9999 with an event:
  - WRAP=0: score stays 9999; sat <= 1.
  - WRAP=1: score -> 0000; sat stays 0.
- On over in PLAY:
  - Let s' = score including any same-cycle increment.
  - If s' > best (unsigned compare of the packed BCD values is valid), then best <= s' and new_best <= 1.
  - Equal score does not set new_best.
- x = show_best ? best : score. No added latency.

## Timing
- Reset values: state IDLE, score 0000, best 0000, x 0000, playing 0, new_best 0, sat 0, inc_q 1.
- inc_q resets to 1 so that inc held high across reset release is not an event. inc must fall and rise again.
- Latency: an inc rising edge sampled at edge k updates score at edge k; the new value is visible on score/x right after edge k.
- Back-to-back: inc toggling every cycle (1,0,1,0) gives one increment per two cycles. inc held high gives exactly one increment.
- Simultaneous events:
  - start + over, same cycle: start wins. Result is PLAY with score 0000; best is not updated.
  - start + inc edge: the edge is discarded; score = 0000.
  - over + inc edge in PLAY: the increment is applied first, then compared and latched into best. Final score includes the increment.
  - Event in IDLE/OVER: ignored; score frozen.
- clr mid-game: all registers return to reset values immediately (asynchronous). best is lost.
- show_best may change any cycle; x follows combinationally within the same cycle.

## Test plan
- Reset then idle: assert clr, release, hold inc=1 for 5 cycles -> score=0000, x=0000, playing=0, no increment.
- Count with carry chain: start, then 1099 inc edges -> score=16'h1099. One more -> 16'h1100. Check every nibble stays <= 9 throughout.
- Saturation (WRAP=0): reach 9999, give 3 more edges -> score=16'h9999, sat=1. Same run with WRAP=1 -> 16'h0000 after the first extra edge, sat=0.
- Best tracking: game 1 scores 0042 then over -> best=0042, new_best=1. Game 2 scores 0042 then over -> best=0042, new_best=0. Game 3 scores 0105 with over on the same cycle as the final inc edge -> best=0105, new_best=1. show_best=1 -> x=16'h0105.
- Simultaneous start+over in PLAY at score 0077 with best 0010 -> state PLAY, score=0000, best=0010, new_best=0.
- clr asserted mid-game (score 0300, best 0500) between clock edges -> all outputs 0 before the next cclk edge. The next start gives best=0000.

Source files
------------

// File: rtl/score_bcd.sv
// Game score keeper: 4-digit packed BCD score with best-score tracking and an
// IDLE/PLAY/OVER state machine, feeding the seven-segment scan driver.
module score_bcd #(
  parameter bit WRAP = 1'b0
) (
  input  logic        cclk,
  input  logic        clr,
  input  logic        start,
  input  logic        over,
  input  logic        inc,
  input  logic        show_best,
  output logic [15:0] x,
  output logic [15:0] score,
  output logic [15:0] best,
  output logic        playing,
  output logic        new_best,
  output logic        sat
);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  state_t      state, state_nx;
  logic        inc_q;
  logic [15:0] score_inc, score_nx, best_nx;
  logic        new_best_nx, sat_nx;
  logic        carry, event_ok, over_ok, at_max, beats;

  // Ripple BCD increment; carry stops at the first digit that is not 9.
  always_comb begin
    carry     = 1'b1;
    score_inc = score;
    for (int unsigned d = 0; d < 4; d++) begin
      if (carry) begin
        if (score[4*d +: 4] == 4'd9) begin
          score_inc[4*d +: 4] = 4'd0;
        end else begin
          score_inc[4*d +: 4] = score[4*d +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    at_max = (score == 16'h9999);
    if (at_max && !WRAP) score_inc = score;
  end

  always_comb begin
    state_nx    = state;
    score_nx    = score;
    best_nx     = best;
    new_best_nx = new_best;
    sat_nx      = sat;
    event_ok    = inc && !inc_q && (state == PLAY) && !start;
    over_ok     = over && (state == PLAY) && !start;
    beats       = 1'b0;

    if (start) begin
      state_nx    = PLAY;
      score_nx    = '0;
      new_best_nx = 1'b0;
      sat_nx      = 1'b0;
    end else begin
      if (event_ok) begin
        score_nx = score_inc;
        if (at_max && !WRAP) sat_nx = 1'b1;
      end
      // The best compare sees the score including a same-cycle increment.
      beats = over_ok && (score_nx > best);
      if (beats) begin
        best_nx     = score_nx;
        new_best_nx = 1'b1;
      end
      if (over_ok) state_nx = OVER;
    end
  end

  always_ff @(posedge cclk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      inc_q    <= 1'b1;
      score    <= '0;
      best     <= '0;
      new_best <= 1'b0;
      sat      <= 1'b0;
    end else begin
      state    <= state_nx;
      inc_q    <= inc;
      score    <= score_nx;
      best     <= best_nx;
      new_best <= new_best_nx;
      sat      <= sat_nx;
    end
  end

  assign playing = (state == PLAY);
  assign x       = show_best ? best : score;

endmodule

// File: tb/tb_score_bcd.sv
// Self-checking bench for score_bcd: a saturating and a wrapping instance share
// stimulus and are compared each cycle against a decimal-integer model.
module tb_score_bcd;

  logic cclk = 1'b0;
  logic clr = 1'b0, start = 1'b0, over = 1'b0, inc = 1'b0, show_best = 1'b0;
  logic [15:0] x0, score0, best0, x1, score1, best1;
  logic playing0, new_best0, sat0, playing1, new_best1, sat1;

  int checks = 0;
  int passed = 0;
  bit done = 1'b0;

  score_bcd #(.WRAP(1'b0)) dut0 (
    .cclk(cclk), .clr(clr), .start(start), .over(over), .inc(inc),
    .show_best(show_best), .x(x0), .score(score0), .best(best0),
    .playing(playing0), .new_best(new_best0), .sat(sat0)
  );

  score_bcd #(.WRAP(1'b1)) dut1 (
    .cclk(cclk), .clr(clr), .start(start), .over(over), .inc(inc),
    .show_best(show_best), .x(x1), .score(score1), .best(best1),
    .playing(playing1), .new_best(new_best1), .sat(sat1)
  );

  always #5 cclk = ~cclk;

  // Model: scores held as plain decimal integers, index 0 saturates, 1 wraps.
  int m_score [2] = '{0, 0};
  int m_best  [2] = '{0, 0};
  bit m_nb    [2] = '{0, 0};
  bit m_sat   [2] = '{0, 0};
  bit m_play = 1'b0;
  bit m_inc_q = 1'b1;

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always @(posedge cclk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < 2; i++) begin
        m_score[i] = 0; m_best[i] = 0; m_nb[i] = 0; m_sat[i] = 0;
      end
      m_play = 1'b0;
      m_inc_q = 1'b1;
    end else begin
      bit ev, was_play;
      ev = inc && !m_inc_q;
      m_inc_q = inc;
      was_play = m_play;
      for (int i = 0; i < 2; i++) begin
        if (start) begin
          m_score[i] = 0; m_nb[i] = 0; m_sat[i] = 0;
        end else if (was_play) begin
          if (ev) begin
            if (m_score[i] == 9999) begin
              if (i == 0) m_sat[i] = 1; else m_score[i] = 0;
            end else m_score[i] = m_score[i] + 1;
          end
          if (over && m_score[i] > m_best[i]) begin
            m_best[i] = m_score[i]; m_nb[i] = 1;
          end
        end
      end
      if (start) m_play = 1'b1;
      else if (over && was_play) m_play = 1'b0;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge cclk) begin
    if (!done) begin
      logic [15:0] e0, e1;
      e0 = to_bcd(m_score[0]);
      e1 = to_bcd(m_score[1]);
      check("score0", score0, e0);
      check("score1", score1, e1);
      check("best0", best0, to_bcd(m_best[0]));
      check("best1", best1, to_bcd(m_best[1]));
      check("x0", x0, show_best ? to_bcd(m_best[0]) : e0);
      check("x1", x1, show_best ? to_bcd(m_best[1]) : e1);
      check("playing0", 16'(playing0), 16'(m_play));
      check("playing1", 16'(playing1), 16'(m_play));
      check("new_best0", 16'(new_best0), 16'(m_nb[0]));
      check("new_best1", 16'(new_best1), 16'(m_nb[1]));
      check("sat0", 16'(sat0), 16'(m_sat[0]));
      check("sat1", 16'(sat1), 16'(m_sat[1]));
      for (int d = 0; d < 4; d++) begin
        logic [15:0] s;
        s = score0;
        check("nibble_le9", 16'(s[4*d +: 4] <= 4'd9), 16'd1);
      end
    end
  end

  task automatic tick();
    @(posedge cclk);
    #1;
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) begin
      inc = 1'b1; tick();
      inc = 1'b0; tick();
    end
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic do_over();
    over = 1'b1; tick(); over = 1'b0;
  endtask

  task automatic pulse_clr();
    #2 clr = 1'b1;
    #2 clr = 1'b0;
    tick();
  endtask

  initial begin
    // Reset and idle with inc held high.
    inc = 1'b1;
    #1 clr = 1'b1;
    #2;
    check("rst_score", score0, 16'h0000);
    check("rst_best", best0, 16'h0000);
    check("rst_x", x0, 16'h0000);
    check("rst_playing", 16'(playing0), 16'd0);
    #10 clr = 1'b0;
    repeat (5) tick();
    check("idle_score", score0, 16'h0000);
    check("idle_playing", 16'(playing0), 16'd0);
    inc = 1'b0;
    tick();

    // Carry chain.
    do_start();
    check("play", 16'(playing0), 16'd1);
    edges(1099);
    check("cnt_1099", score0, 16'h1099);
    edges(1);
    check("cnt_1100", score0, 16'h1100);

    // Saturate vs wrap.
    edges(8899);
    check("at_9999_sat", score0, 16'h9999);
    check("at_9999_wrap", score1, 16'h9999);
    edges(1);
    check("wrap_0000", score1, 16'h0000);
    check("wrap_sat", 16'(sat1), 16'd0);
    edges(2);
    check("sat_9999", score0, 16'h9999);
    check("sat_flag", 16'(sat0), 16'd1);
    check("wrap_0002", score1, 16'h0002);

    // Best tracking.
    pulse_clr();
    do_start(); edges(42); do_over();
    check("g1_best", best0, 16'h0042);
    check("g1_nb", 16'(new_best0), 16'd1);
    edges(3);
    check("over_frozen", score0, 16'h0042);
    do_start(); edges(42); do_over();
    check("g2_best", best0, 16'h0042);
    check("g2_nb", 16'(new_best0), 16'd0);
    do_start(); edges(104);
    inc = 1'b1; over = 1'b1; tick(); inc = 1'b0; over = 1'b0;
    check("g3_score", score0, 16'h0105);
    check("g3_best", best0, 16'h0105);
    check("g3_nb", 16'(new_best0), 16'd1);
    show_best = 1'b1; #1;
    check("show_best_x", x0, 16'h0105);
    tick(); show_best = 1'b0; #1;
    check("show_score_x", x0, 16'h0105);

    // start + over, then start + inc edge.
    pulse_clr();
    do_start(); edges(10); do_over();
    do_start(); edges(77);
    check("pre_so_score", score0, 16'h0077);
    start = 1'b1; over = 1'b1; tick(); start = 1'b0; over = 1'b0;
    check("so_play", 16'(playing0), 16'd1);
    check("so_score", score0, 16'h0000);
    check("so_best", best0, 16'h0010);
    check("so_nb", 16'(new_best0), 16'd0);
    edges(5);
    start = 1'b1; inc = 1'b1; tick(); start = 1'b0; inc = 1'b0;
    check("si_score", score0, 16'h0000);
    tick();

    // Asynchronous clr mid-game.
    pulse_clr();
    do_start(); edges(500); do_over();
    do_start(); edges(300);
    check("pre_clr_score", score0, 16'h0300);
    check("pre_clr_best", best0, 16'h0500);
    #2 clr = 1'b1;
    #1;
    check("aclr_score", score0, 16'h0000);
    check("aclr_best", best0, 16'h0000);
    check("aclr_x", x0, 16'h0000);
    check("aclr_playing", 16'(playing0), 16'd0);
    #2 clr = 1'b0;
    tick();
    do_start(); edges(2);
    check("post_clr_best", best0, 16'h0000);
    check("post_clr_score", score0, 16'h0002);

    tick();
    done = 1'b1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
